// File: rtl/wb_exc_commit_pkg.sv
// Shared constants and types for the writeback/commit stage: exception codes,
// exception-vector bit positions and the flush FSM encoding.
package wb_exc_commit_pkg;

  localparam int EXV_W = 6;

  // ex_vec bit order {ALE,BRK,SYS,INE,ADEF,rsvd}
  localparam int EXV_ADEF = 1;
  localparam int EXV_INE  = 2;
  localparam int EXV_SYS  = 3;
  localparam int EXV_BRK  = 4;
  localparam int EXV_ALE  = 5;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [8:0] ESUBCODE_NONE = 9'h000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ws_state_e;

endpackage

// File: rtl/wb_exc_commit_ex_prio_enc.sv
// Combinational exception priority encoder: interrupt first, then the
// instruction-raised causes from oldest pipeline stage to youngest.
module ex_prio_enc
  import wb_exc_commit_pkg::*;
#(
  parameter int EXV_W = wb_exc_commit_pkg::EXV_W
) (
  input  logic             has_int,
  input  logic [EXV_W-1:0] ex_vec,
  output logic             hit,
  output logic [5:0]       ecode,
  output logic [8:0]       esubcode
);

  // NOTE: every output gets a default before the if-chain so no path leaves
  // a value held, which would otherwise infer a latch.
  always_comb begin
    hit      = has_int || (|ex_vec);
    ecode    = ECODE_INT;
    esubcode = ESUBCODE_NONE;
    if (has_int)                ecode = ECODE_INT;
    else if (ex_vec[EXV_ADEF])  ecode = ECODE_ADE;
    else if (ex_vec[EXV_INE])   ecode = ECODE_INE;
    else if (ex_vec[EXV_SYS])   ecode = ECODE_SYS;
    else if (ex_vec[EXV_BRK])   ecode = ECODE_BRK;
    else if (ex_vec[EXV_ALE])   ecode = ECODE_ALE;
  end

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback/commit stage: WB pipeline register, precise exception/ERTN
// resolution, CSR/regfile strobes and a one-cycle registered pipeline flush.
module wb_exc_commit
  import wb_exc_commit_pkg::*;
#(
  parameter int EXV_W = wb_exc_commit_pkg::EXV_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ms_to_ws_valid,
  output logic             ws_allowin,
  input  logic [31:0]      ms_pc,
  input  logic [EXV_W-1:0] ms_ex_vec,
  input  logic [31:0]      ms_vaddr,
  input  logic             ms_ertn,
  input  logic             ms_csr_re,
  input  logic             ms_csr_we,
  input  logic [13:0]      ms_csr_num,
  input  logic [31:0]      ms_csr_wmask,
  input  logic [31:0]      ms_csr_wvalue,
  input  logic             ms_rf_we,
  input  logic [4:0]       ms_rf_waddr,
  input  logic [31:0]      ms_rf_wdata,
  input  logic             has_int,
  input  logic [31:0]      csr_rvalue,
  input  logic [31:0]      ex_entry,
  input  logic [31:0]      era_pc,
  output logic [13:0]      csr_num,
  output logic             csr_we,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_vaddr,
  output logic             ertn_flush,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  typedef struct packed {
    logic [31:0]      pc;
    logic [EXV_W-1:0] ex_vec;
    logic [31:0]      vaddr;
    logic             ertn;
    logic             csr_re;
    logic             csr_we;
    logic [13:0]      csr_num;
    logic [31:0]      csr_wmask;
    logic [31:0]      csr_wvalue;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
  } ws_reg_t;

  ws_reg_t   ws_q, ws_d;
  logic      ws_valid_q, ws_valid_d;
  ws_state_e state_q, state_d;
  logic      kind_ex_q, kind_ex_d;

  logic       enc_hit;
  logic [5:0] enc_ecode;
  logic [8:0] enc_esub;
  logic       ex_hit, ertn_hit, commit_flush, accept;

  ex_prio_enc #(.EXV_W(EXV_W)) u_prio (
    .has_int  (has_int),
    .ex_vec   (ws_q.ex_vec),
    .hit      (enc_hit),
    .ecode    (enc_ecode),
    .esubcode (enc_esub)
  );

  assign ex_hit       = ws_valid_q && enc_hit;
  assign ertn_hit     = ws_valid_q && ws_q.ertn && !ex_hit;
  assign commit_flush = ex_hit || ertn_hit;
  // Younger offers seen during a commit-flush or the FLUSH cycle are discarded.
  assign accept       = ms_to_ws_valid && (state_q == ST_RUN) && !commit_flush;
  assign ws_allowin   = 1'b1;

  always_comb begin
    ws_valid_d = accept;
    ws_d       = ws_q;
    if (accept) begin
      ws_d = '{pc: ms_pc, ex_vec: ms_ex_vec, vaddr: ms_vaddr, ertn: ms_ertn,
               csr_re: ms_csr_re, csr_we: ms_csr_we, csr_num: ms_csr_num,
               csr_wmask: ms_csr_wmask, csr_wvalue: ms_csr_wvalue,
               rf_we: ms_rf_we, rf_waddr: ms_rf_waddr, rf_wdata: ms_rf_wdata};
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_ex_d = kind_ex_q;
    case (state_q)
      ST_RUN: if (commit_flush) begin
        state_d   = ST_FLUSH;
        kind_ex_d = ex_hit;
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      state_q    <= ST_RUN;
      kind_ex_q  <= 1'b0;
    end else begin
      ws_valid_q <= ws_valid_d;
      state_q    <= state_d;
      kind_ex_q  <= kind_ex_d;
    end
  end

  // NOTE: the payload is left unreset on purpose; every consumer is qualified
  // by ws_valid_q, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    ws_q <= ws_d;
  end

  always_comb begin
    csr_num     = ws_valid_q ? ws_q.csr_num : 14'h0;
    csr_wmask   = ws_q.csr_wmask;
    csr_wvalue  = ws_q.csr_wvalue;
    csr_we      = ws_valid_q && !commit_flush && ws_q.csr_we;
    rf_we       = ws_valid_q && !commit_flush && ws_q.rf_we;
    rf_waddr    = ws_q.rf_waddr;
    rf_wdata    = ws_q.csr_re ? csr_rvalue : ws_q.rf_wdata;
    wb_ex       = ex_hit;
    wb_ecode    = ex_hit ? enc_ecode : 6'h0;
    wb_esubcode = ex_hit ? enc_esub : 9'h0;
    wb_pc       = ex_hit ? ws_q.pc : 32'h0;
    wb_vaddr    = ex_hit ? ws_q.vaddr : 32'h0;
    ertn_flush  = ertn_hit;
    flush       = (state_q == ST_FLUSH);
    // Target is read in the FLUSH cycle, after the CSR file has updated.
    flush_pc    = 32'h0;
    if (state_q == ST_FLUSH) flush_pc = kind_ex_q ? ex_entry : era_pc;
  end

endmodule

// File: tb/tb_wb_exc_commit.sv
// Self-checking bench for wb_exc_commit: directed scenarios followed by a
// randomized run checked against a cycle-level commit model.
module tb_wb_exc_commit;

  logic        clk, resetn;
  logic        ms_to_ws_valid, ws_allowin;
  logic [31:0] ms_pc;
  logic [5:0]  ms_ex_vec;
  logic [31:0] ms_vaddr;
  logic        ms_ertn, ms_csr_re, ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask, ms_csr_wvalue;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        has_int;
  logic [31:0] csr_rvalue, ex_entry, era_pc;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush;
  logic [31:0] flush_pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [5:0]  exv;
    logic [31:0] vaddr;
    logic        ertn, cre, cwe;
    logic [13:0] num;
    logic [31:0] mask, wval;
    logic        rwe;
    logic [4:0]  wa;
    logic [31:0] wd;
  } instr_t;

  wb_exc_commit dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_ex_vec(ms_ex_vec), .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn),
    .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata), .has_int(has_int),
    .csr_rvalue(csr_rvalue), .ex_entry(ex_entry), .era_pc(era_pc), .csr_num(csr_num),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .ertn_flush(ertn_flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t nop();
    instr_t i;
    i = '{v: 1'b0, pc: 32'h0, exv: 6'h0, vaddr: 32'h0, ertn: 1'b0, cre: 1'b0, cwe: 1'b0,
          num: 14'h0, mask: 32'h0, wval: 32'h0, rwe: 1'b0, wa: 5'h0, wd: 32'h0};
    return i;
  endfunction

  function automatic instr_t add_w(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res);
    instr_t i;
    i = nop();
    i.v = 1'b1; i.pc = pc; i.rwe = 1'b1; i.wa = rd; i.wd = res;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ms_to_ws_valid = i.v;    ms_pc = i.pc;         ms_ex_vec = i.exv;   ms_vaddr = i.vaddr;
    ms_ertn = i.ertn;        ms_csr_re = i.cre;    ms_csr_we = i.cwe;   ms_csr_num = i.num;
    ms_csr_wmask = i.mask;   ms_csr_wvalue = i.wval;
    ms_rf_we = i.rwe;        ms_rf_waddr = i.wa;   ms_rf_wdata = i.wd;
  endtask

  // Cause code from the architectural priority list, highest first.
  function automatic logic [5:0] cause_of(input logic irq, input logic [5:0] exv);
    int          order [5] = '{1, 2, 3, 4, 5};
    logic [5:0]  codes [5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
    if (irq) return 6'h00;
    foreach (order[k]) if (exv[order[k]]) return codes[k];
    return 6'h00;
  endfunction

  task automatic test_reset();
    drive(nop()); has_int = 0; csr_rvalue = 0; ex_entry = 32'h1c008000; era_pc = 0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin bad++; $display("FAIL reset_flush got=%b/%h exp=0/0", flush, flush_pc); end
    total++; if ({wb_ex, rf_we, csr_we, ertn_flush} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {wb_ex, rf_we, csr_we, ertn_flush}); end
    total++; if (ws_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b exp=1", ws_allowin); end
    resetn = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk); drive(add_w(32'h1c000000, 5'd4, 32'h0000_1234));
    @(negedge clk); drive(nop()); #1;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h1234) begin bad++; $display("FAIL add_rf got=%b/%0d/%h exp=1/4/1234", rf_we, rf_waddr, rf_wdata); end
    total++; if (wb_ex !== 1'b0 || csr_we !== 1'b0) begin bad++; $display("FAIL add_noex got=%b/%b exp=0/0", wb_ex, csr_we); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      total++; if (flush !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL add_idle got=%b/%b exp=0/0", flush, rf_we); end
    end
  endtask

  task automatic test_sys();
    instr_t i;
    i = add_w(32'h1c000100, 5'd9, 32'hdead); i.exv = 6'h08;
    ex_entry = 32'h1c008000;
    @(negedge clk); drive(i);
    @(negedge clk); drive(add_w(32'h1c000104, 5'd5, 32'h55)); #1;
    total++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h0B || wb_esubcode !== 9'h0) begin bad++; $display("FAIL sys_cause got=%b/%h/%h exp=1/0b/0", wb_ex, wb_ecode, wb_esubcode); end
    total++; if (wb_pc !== 32'h1c000100 || rf_we !== 1'b0) begin bad++; $display("FAIL sys_pc got=%h/%b exp=1c000100/0", wb_pc, rf_we); end
    @(negedge clk); drive(add_w(32'h1c000108, 5'd6, 32'h66)); #1;
    total++; if (flush !== 1'b1 || flush_pc !== 32'h1c008000) begin bad++; $display("FAIL sys_flush got=%b/%h exp=1/1c008000", flush, flush_pc); end
    total++; if (wb_ex !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL sys_flushcyc got=%b/%b exp=0/0", wb_ex, rf_we); end
    @(negedge clk); drive(nop()); #1;
    total++; if (flush !== 1'b0 || rf_we !== 1'b0 || wb_ex !== 1'b0) begin bad++; $display("FAIL sys_dropped got=%b/%b/%b exp=0/0/0", flush, rf_we, wb_ex); end
  endtask

  task automatic test_int_over_ale();
    instr_t i;
    i = add_w(32'h1c000200, 5'd3, 32'h1); i.exv = 6'h20; i.vaddr = 32'h3;
    @(negedge clk); drive(i);
    @(negedge clk); drive(nop()); has_int = 1'b1; #1;
    total++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h00) begin bad++; $display("FAIL int_ale got=%b/%h exp=1/00", wb_ex, wb_ecode); end
    total++; if (wb_vaddr !== 32'h3 || wb_pc !== 32'h1c000200) begin bad++; $display("FAIL int_ale_addr got=%h/%h exp=3/1c000200", wb_vaddr, wb_pc); end
    @(negedge clk); has_int = 1'b0; #1;
    total++; if (flush !== 1'b1 || flush_pc !== ex_entry) begin bad++; $display("FAIL int_flush got=%b/%h exp=1/%h", flush, flush_pc, ex_entry); end
    @(negedge clk);
  endtask

  task automatic test_ertn();
    instr_t i;
    i = add_w(32'h1c000300, 5'd1, 32'h7); i.ertn = 1'b1;
    era_pc = 32'h1c000204;
    @(negedge clk); drive(i);
    @(negedge clk); drive(nop()); #1;
    total++; if (ertn_flush !== 1'b1 || wb_ex !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL ertn_commit got=%b/%b/%b exp=1/0/0", ertn_flush, wb_ex, rf_we); end
    @(negedge clk); #1;
    total++; if (flush !== 1'b1 || flush_pc !== 32'h1c000204 || ertn_flush !== 1'b0) begin bad++; $display("FAIL ertn_flush got=%b/%h/%b exp=1/1c000204/0", flush, flush_pc, ertn_flush); end
    @(negedge clk);
  endtask

  task automatic test_csr();
    instr_t i;
    i = add_w(32'h1c000400, 5'd7, 32'hbad0bad0); i.cre = 1'b1; i.num = 14'h5;
    @(negedge clk); drive(i);
    @(negedge clk); csr_rvalue = 32'hABCD0001;
    i = nop(); i.v = 1'b1; i.pc = 32'h1c000404; i.cwe = 1'b1; i.num = 14'h6;
    i.mask = 32'hFFFFFFFF; i.wval = 32'h1c00_0abc; drive(i); #1;
    total++; if (rf_we !== 1'b1 || rf_wdata !== 32'hABCD0001 || csr_num !== 14'h5 || csr_we !== 1'b0) begin bad++; $display("FAIL csrrd got=%b/%h/%h/%b exp=1/abcd0001/5/0", rf_we, rf_wdata, csr_num, csr_we); end
    @(negedge clk); drive(nop()); #1;
    total++; if (csr_we !== 1'b1 || csr_wmask !== 32'hFFFFFFFF || csr_wvalue !== 32'h1c000abc || csr_num !== 14'h6) begin bad++; $display("FAIL csrwr got=%b/%h/%h/%h exp=1/ffffffff/1c000abc/6", csr_we, csr_wmask, csr_wvalue, csr_num); end
    @(negedge clk); #1;
    total++; if (csr_we !== 1'b0) begin bad++; $display("FAIL csrwr_once got=%b exp=0", csr_we); end
  endtask

  task automatic test_reset_mid_flush();
    instr_t i;
    i = add_w(32'h1c000500, 5'd2, 32'h2); i.exv = 6'h10;
    @(negedge clk); drive(i);
    @(negedge clk); drive(add_w(32'h1c000504, 5'd8, 32'h8));
    @(negedge clk); drive(nop()); #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL rst_pre got=%b exp=1", flush); end
    #1 resetn = 1'b0; #1;
    total++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin bad++; $display("FAIL rst_async got=%b/%h exp=0/0", flush, flush_pc); end
    total++; if ({wb_ex, rf_we, csr_we, ertn_flush} !== 4'b0) begin bad++; $display("FAIL rst_strobes got=%b exp=0000", {wb_ex, rf_we, csr_we, ertn_flush}); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); #1;
    total++; if (flush !== 1'b0 || rf_we !== 1'b0 || wb_ex !== 1'b0) begin bad++; $display("FAIL rst_after got=%b/%b/%b exp=0/0/0", flush, rf_we, wb_ex); end
  endtask

  task automatic test_random();
    instr_t wb, off;
    logic   fl_pend, fl_ex, e_ex, e_ertn;
    wb = nop(); fl_pend = 1'b0; fl_ex = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      off = nop();
      off.v = ($urandom_range(0, 3) != 0);
      off.pc = {$urandom} & 32'hFFFF_FFFC; off.vaddr = $urandom;
      off.exv = ($urandom_range(0, 5) == 0) ? 6'($urandom & 32'h3E) : 6'h0;
      off.ertn = ($urandom_range(0, 9) == 0);
      off.cre = ($urandom_range(0, 3) == 0); off.cwe = ($urandom_range(0, 3) == 0);
      off.num = 14'($urandom); off.mask = $urandom; off.wval = $urandom;
      off.rwe = $urandom_range(0, 1); off.wa = 5'($urandom); off.wd = $urandom;
      drive(off);
      has_int = ($urandom_range(0, 15) == 0);
      csr_rvalue = $urandom; ex_entry = $urandom; era_pc = $urandom;
      #1;
      e_ex   = wb.v && (has_int || (wb.exv != 0));
      e_ertn = wb.v && wb.ertn && !e_ex;
      total++; if (wb_ex !== e_ex || ertn_flush !== e_ertn) begin bad++; $display("FAIL rnd_ex c=%0d got=%b/%b exp=%b/%b", c, wb_ex, ertn_flush, e_ex, e_ertn); end
      if (e_ex) begin
        total++; if (wb_ecode !== cause_of(has_int, wb.exv) || wb_pc !== wb.pc || wb_vaddr !== wb.vaddr) begin bad++; $display("FAIL rnd_cause c=%0d got=%h/%h/%h exp=%h/%h/%h", c, wb_ecode, wb_pc, wb_vaddr, cause_of(has_int, wb.exv), wb.pc, wb.vaddr); end
      end
      total++; if (rf_we !== (wb.v && wb.rwe && !e_ex && !e_ertn)) begin bad++; $display("FAIL rnd_rfwe c=%0d got=%b", c, rf_we); end
      if (rf_we === 1'b1) begin
        total++; if (rf_waddr !== wb.wa || rf_wdata !== (wb.cre ? csr_rvalue : wb.wd)) begin bad++; $display("FAIL rnd_rfdata c=%0d got=%0d/%h", c, rf_waddr, rf_wdata); end
      end
      total++; if (csr_we !== (wb.v && wb.cwe && !e_ex && !e_ertn)) begin bad++; $display("FAIL rnd_csrwe c=%0d got=%b", c, csr_we); end
      if (csr_we === 1'b1) begin
        total++; if (csr_num !== wb.num || csr_wmask !== wb.mask || csr_wvalue !== wb.wval) begin bad++; $display("FAIL rnd_csrdata c=%0d got=%h/%h/%h", c, csr_num, csr_wmask, csr_wvalue); end
      end
      total++; if (flush !== fl_pend || flush_pc !== (fl_pend ? (fl_ex ? ex_entry : era_pc) : 32'h0)) begin bad++; $display("FAIL rnd_flush c=%0d got=%b/%h exp=%b", c, flush, flush_pc, fl_pend); end
      // Model advance: a flushing commit or a FLUSH cycle swallows the offer.
      if (!(e_ex || e_ertn || fl_pend) && off.v) wb = off; else wb = nop();
      fl_ex   = e_ex;
      fl_pend = e_ex || e_ertn;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sys();
    test_int_over_ale();
    test_ertn();
    test_csr();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
